timer_match_ctrl: RTL and testbench



---
 rtl/timer_match_ctrl.sv | 104 ++++++++++
 tb/tb_timer_match_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_match_ctrl.sv
// timer_match_ctrl: prescaled up-counter with compare match, pulse + sticky irq.
// States: IDLE (frozen), RUN (counting), HOLD (one-shot done, count parked at cmp_r).
module timer_match_ctrl #(
  parameter int N  = 12,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [N-1:0]  cfg_cmp,
  input  logic [PW-1:0] cfg_presc,
  input  logic          cfg_periodic,
  input  logic          start,
  input  logic          stop,
  input  logic          irq_ack,
  output logic [N-1:0]  count,
  output logic          running,
  output logic          match,
  output logic          irq,
  output logic          overrun
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t        state, state_n;
  logic [N-1:0]  cmp_r, count_n;
  logic [PW-1:0] presc_r, pc, pc_n;
  logic          periodic_r;
  logic [N:0]    diff;
  logic          eq, tick, hit;

  // Equality by subtraction: zero difference with no borrow out.
  assign diff = {1'b0, count} - {1'b0, cmp_r};
  assign eq   = ~diff[N] && (diff[N-1:0] == '0);
  assign tick = (state == RUN) && (pc == presc_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and datapath updates; stop outranks start and any same-cycle tick.
  always_comb begin
    state_n = state;
    count_n = count;
    pc_n    = pc;
    hit     = 1'b0;
    if (stop) begin
      state_n = IDLE;
      pc_n    = '0;
    end else if (start && state != RUN) begin
      state_n = RUN;
      count_n = '0;
      pc_n    = '0;
    end else if (state == RUN) begin
      if (tick) begin
        pc_n = '0;
        if (eq) begin
          hit = 1'b1;
          if (periodic_r) count_n = '0;
          else            state_n = HOLD;
        end else begin
          count_n = count + 1'b1;
        end
      end else begin
        pc_n = pc + 1'b1;
      end
    end
  end

  // Datapath, config and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      pc         <= '0;
      cmp_r      <= '0;
      presc_r    <= '0;
      periodic_r <= 1'b0;
      match      <= 1'b0;
      irq        <= 1'b0;
      overrun    <= 1'b0;
      running    <= 1'b0;
    end else begin
      count   <= count_n;
      pc      <= pc_n;
      match   <= hit;
      running <= (state_n == RUN);
      // Config is locked while counting so a run always sees consistent values.
      if (cfg_we && state != RUN) begin
        cmp_r      <= cfg_cmp;
        presc_r    <= cfg_presc;
        periodic_r <= cfg_periodic;
      end
      // A new match wins over ack so no event is lost.
      if (hit)          irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;
      // Ack wins over a coincident overrun.
      if (irq_ack)         overrun <= 1'b0;
      else if (hit && irq) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_match_ctrl.sv
// Directed self-checking bench for timer_match_ctrl.
module tb_timer_match_ctrl;
  localparam int N = 12, PW = 8;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cfg_we = 0, cfg_periodic = 0, start = 0, stop = 0, irq_ack = 0;
  logic [N-1:0]  cfg_cmp = '0;
  logic [PW-1:0] cfg_presc = '0;
  logic [N-1:0]  count;
  logic          running, match, irq, overrun;
  int            pass_cnt = 0, total = 0;

  timer_match_ctrl #(.N(N), .PW(PW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_cmp(cfg_cmp), .cfg_presc(cfg_presc),
    .cfg_periodic(cfg_periodic), .start(start), .stop(stop), .irq_ack(irq_ack),
    .count(count), .running(running), .match(match), .irq(irq), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_start(input logic [N-1:0] c, input logic [PW-1:0] p, input logic per);
    cfg_we = 1; cfg_cmp = c; cfg_presc = p; cfg_periodic = per; start = 1;
    tick(1);
    cfg_we = 0; start = 0;
  endtask

  task automatic test_reset;
    #12;
    total++;
    if ({count, running, match, irq, overrun} !== {12'd0, 4'b0000})
      $display("FAIL reset_state actual=%h expected=%h", {count, running, match, irq, overrun}, {12'd0, 4'b0000});
    else pass_cnt++;
    @(negedge clk) rst = 0;
  endtask

  task automatic test_oneshot;
    cfg_we = 1; cfg_cmp = 3; cfg_presc = 0; cfg_periodic = 0;
    tick(1);
    cfg_we = 0; start = 1;
    tick(1);
    start = 0;
    total++;
    if ({count, running} !== {12'd0, 1'b1})
      $display("FAIL oneshot_start actual=%h expected=%h", {count, running}, {12'd0, 1'b1});
    else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      total++;
      if ({count, match} !== {k[N-1:0], 1'b0})
        $display("FAIL oneshot_count k=%0d actual=%h expected=%h", k, {count, match}, {k[N-1:0], 1'b0});
      else pass_cnt++;
    end
    tick(1);
    total++;
    if ({count, match, irq, running} !== {12'd3, 3'b110})
      $display("FAIL oneshot_match actual=%h expected=%h", {count, match, irq, running}, {12'd3, 3'b110});
    else pass_cnt++;
    tick(1);
    total++;
    if ({count, match, irq, running} !== {12'd3, 3'b010})
      $display("FAIL oneshot_hold actual=%h expected=%h", {count, match, irq, running}, {12'd3, 3'b010});
    else pass_cnt++;
  endtask

  task automatic test_periodic;
    logic [N-1:0] exp_cnt;
    logic         exp_m;
    irq_ack = 1;
    cfg_start(2, 1, 1);
    irq_ack = 0;
    total++;
    if ({count, running, irq} !== {12'd0, 2'b10})
      $display("FAIL periodic_start actual=%h expected=%h", {count, running, irq}, {12'd0, 2'b10});
    else pass_cnt++;
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      exp_cnt = N'((k / 2) % 3);
      exp_m   = (k % 6 == 0);
      total++;
      if ({count, match} !== {exp_cnt, exp_m})
        $display("FAIL periodic_seq k=%0d actual=%h expected=%h", k, {count, match}, {exp_cnt, exp_m});
      else pass_cnt++;
      if (k == 6 || k == 12) begin
        total++;
        if ({irq, overrun} !== {1'b1, k == 12})
          $display("FAIL periodic_flags k=%0d actual=%b expected=%b", k, {irq, overrun}, {1'b1, k == 12});
        else pass_cnt++;
      end
    end
    stop = 1;
    tick(1);
    stop = 0;
    total++;
    if (running !== 1'b0) $display("FAIL periodic_stop actual=%b expected=0", running);
    else pass_cnt++;
  endtask

  task automatic test_overrun;
    irq_ack = 1;
    tick(1);
    irq_ack = 0;
    total++;
    if ({irq, overrun} !== 2'b00) $display("FAIL ack_idle actual=%b expected=00", {irq, overrun});
    else pass_cnt++;
    cfg_start(0, 0, 1);
    tick(1);
    total++;
    if ({match, irq, overrun} !== 3'b110) $display("FAIL ovr_first actual=%b expected=110", {match, irq, overrun});
    else pass_cnt++;
    tick(1);
    total++;
    if ({match, irq, overrun} !== 3'b111) $display("FAIL ovr_second actual=%b expected=111", {match, irq, overrun});
    else pass_cnt++;
    irq_ack = 1;
    tick(1);
    irq_ack = 0;
    total++;
    if ({match, irq, overrun} !== 3'b110) $display("FAIL ack_with_match actual=%b expected=110", {match, irq, overrun});
    else pass_cnt++;
    tick(1);
    total++;
    if (overrun !== 1'b1) $display("FAIL ovr_again actual=%b expected=1", overrun);
    else pass_cnt++;
    stop = 1;
    tick(1);
    stop = 0;
    total++;
    if ({count, match, running} !== {12'd0, 2'b00})
      $display("FAIL stop_on_match actual=%h expected=%h", {count, match, running}, {12'd0, 2'b00});
    else pass_cnt++;
    irq_ack = 1;
    tick(1);
    irq_ack = 0;
    total++;
    if ({irq, overrun} !== 2'b00) $display("FAIL ack_clear actual=%b expected=00", {irq, overrun});
    else pass_cnt++;
  endtask

  task automatic test_stop_priority;
    cfg_start(5, 0, 0);
    tick(5);
    total++;
    if ({count, match} !== {12'd5, 1'b0}) $display("FAIL stop_pre actual=%h expected=%h", {count, match}, {12'd5, 1'b0});
    else pass_cnt++;
    stop = 1;
    tick(1);
    stop = 0;
    total++;
    if ({count, match, running, irq} !== {12'd5, 3'b000})
      $display("FAIL stop_prio actual=%h expected=%h", {count, match, running, irq}, {12'd5, 3'b000});
    else pass_cnt++;
    tick(1);
    total++;
    if ({count, match} !== {12'd5, 1'b0}) $display("FAIL idle_frozen actual=%h expected=%h", {count, match}, {12'd5, 1'b0});
    else pass_cnt++;
    // Config write during RUN must not change cmp_r (still 5).
    start = 1;
    tick(1);
    start = 0;
    cfg_we = 1; cfg_cmp = 9;
    tick(1);
    cfg_we = 0;
    tick(4);
    total++;
    if ({count, match} !== {12'd5, 1'b0}) $display("FAIL cfg_run_pre actual=%h expected=%h", {count, match}, {12'd5, 1'b0});
    else pass_cnt++;
    tick(1);
    total++;
    if ({count, match, running} !== {12'd5, 2'b10})
      $display("FAIL cfg_ignored actual=%h expected=%h", {count, match, running}, {12'd5, 2'b10});
    else pass_cnt++;
    // Start from HOLD restarts at 0.
    tick(1);
    start = 1;
    tick(1);
    start = 0;
    total++;
    if ({count, running} !== {12'd0, 1'b1}) $display("FAIL hold_restart actual=%h expected=%h", {count, running}, {12'd0, 1'b1});
    else pass_cnt++;
    stop = 1; irq_ack = 1;
    tick(1);
    stop = 0; irq_ack = 0;
  endtask

  task automatic test_edges;
    cfg_start(0, 3, 0);
    tick(3);
    total++;
    if ({match, running} !== 2'b01) $display("FAIL cmp0_early actual=%b expected=01", {match, running});
    else pass_cnt++;
    tick(1);
    total++;
    if ({count, match, running} !== {12'd0, 2'b10})
      $display("FAIL cmp0_match actual=%h expected=%h", {count, match, running}, {12'd0, 2'b10});
    else pass_cnt++;
    cfg_start(12'd4095, 0, 0);
    tick(4095);
    total++;
    if ({count, match, running} !== {12'd4095, 2'b01})
      $display("FAIL max_pre actual=%h expected=%h", {count, match, running}, {12'd4095, 2'b01});
    else pass_cnt++;
    tick(1);
    total++;
    if ({count, match, running} !== {12'd4095, 2'b10})
      $display("FAIL max_match actual=%h expected=%h", {count, match, running}, {12'd4095, 2'b10});
    else pass_cnt++;
    tick(1);
    total++;
    if ({count, match, running} !== {12'd4095, 2'b00})
      $display("FAIL max_nowrap actual=%h expected=%h", {count, match, running}, {12'd4095, 2'b00});
    else pass_cnt++;
  endtask

  task automatic test_reset_midrun;
    cfg_start(100, 0, 0);
    tick(37);
    total++;
    if ({count, irq} !== {12'd37, 1'b1}) $display("FAIL rst_pre actual=%h expected=%h", {count, irq}, {12'd37, 1'b1});
    else pass_cnt++;
    #2 rst = 1;
    #1;
    total++;
    if ({count, running, match, irq, overrun} !== {12'd0, 4'b0000})
      $display("FAIL rst_async actual=%h expected=%h", {count, running, match, irq, overrun}, {12'd0, 4'b0000});
    else pass_cnt++;
    @(negedge clk) rst = 0;
    start = 1;
    tick(1);
    start = 0;
    total++;
    if ({count, running} !== {12'd0, 1'b1}) $display("FAIL rst_restart actual=%h expected=%h", {count, running}, {12'd0, 1'b1});
    else pass_cnt++;
    tick(1);
    total++;
    if ({count, match, running, irq} !== {12'd0, 3'b101})
      $display("FAIL rst_cfg_zero actual=%h expected=%h", {count, match, running, irq}, {12'd0, 3'b101});
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_periodic;
    test_overrun;
    test_stop_priority;
    test_edges;
    test_reset_midrun;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
